instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit.sv | 80 ++++++++
 tb/tb_instr_fetch_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC/IR fetch sequencer driving the decoder and picking the next PC.
// FETCH_TIMEOUT_EN adds a fetch watchdog (TIMEOUT parameter) and the sticky fetch_fault output.
module instr_fetch_unit #(
  parameter int PC_W = 8,
  parameter int INSTR_W = 32
`ifdef FETCH_TIMEOUT_EN
  , parameter int TIMEOUT = 16
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  output logic [7:0]         opcode,
  output logic [INSTR_W-9:0] operand,
  output logic               instr_valid,
  input  logic               jmp,
  input  logic               jmp_if,
  input  logic               cond_true,
  input  logic               halt,
  output logic [PC_W-1:0]    pc,
  output logic               halted
`ifdef FETCH_TIMEOUT_EN
  , output logic             fetch_fault
`endif
);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALTED} state_t;
  state_t state, state_n;
  logic [PC_W-1:0] pc_n;
  logic [INSTR_W-1:0] ir;
  logic expire;
  assign imem_req = state == FETCH;
  assign imem_addr = pc;
  assign instr_valid = state == EXEC;
  assign halted = state == HALTED;
  assign opcode = ir[INSTR_W-1:INSTR_W-8];
  assign operand = ir[INSTR_W-9:0];
`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  assign expire = state == FETCH && !imem_valid && cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      fetch_fault <= 1'b0;
    end else begin
      cnt <= state == FETCH ? cnt + CW'(1) : '0;
      if (expire) fetch_fault <= 1'b1;
    end
`else
  assign expire = 1'b0;
`endif
  always_comb begin
    state_n = state;
    pc_n = pc;
    case (state)
      IDLE:  state_n = run ? FETCH : IDLE;
      FETCH: state_n = imem_valid ? EXEC : expire ? HALTED : FETCH;
      EXEC: begin
        state_n = halt ? HALTED : FETCH;
        pc_n = halt ? pc : (jmp || (jmp_if && cond_true)) ? ir[PC_W-1:0] : pc + PC_W'(1);
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc <= '0;
      ir <= '0;
    end else begin
      pc <= pc_n;
      if (state == FETCH && imem_valid) ir <= imem_rdata;
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed-vector bench for instr_fetch_unit (default build, PC_W=8, INSTR_W=32).
module tb_instr_fetch_unit;
  logic clk = 1'b0, rst = 1'b1, run = 1'b0;
  logic imem_req, imem_valid = 1'b0, instr_valid, halted;
  logic jmp = 1'b0, jmp_if = 1'b0, cond_true = 1'b0, halt = 1'b0;
  logic [7:0] imem_addr, pc, opcode;
  logic [31:0] imem_rdata = '0;
  logic [23:0] operand;
  int vectors = 0, errs = 0;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .run(run), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .opcode(opcode), .operand(operand),
    .instr_valid(instr_valid), .jmp(jmp), .jmp_if(jmp_if), .cond_true(cond_true),
    .halt(halt), .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fetch_word(input logic [31:0] w);
    imem_valid = 1'b1;
    imem_rdata = w;
    tick();
    imem_valid = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_pc", pc, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_iv", instr_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_operand", operand, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("idle_no_run_req", imem_req, 0);
    // zero-wait fetch; valid held high while still in IDLE must be ignored
    run = 1'b1;
    imem_valid = 1'b1;
    imem_rdata = 32'h0301002A;
    tick();
    run = 1'b0;
    chk("f0_req", imem_req, 1);
    chk("f0_addr", imem_addr, 8'h00);
    chk("f0_opcode_pre", opcode, 0);
    tick();
    imem_valid = 1'b0;
    chk("e0_iv", instr_valid, 1);
    chk("e0_req", imem_req, 0);
    chk("e0_opcode", opcode, 8'h03);
    chk("e0_operand", operand, 24'h01002A);
    tick();
    chk("f1_iv", instr_valid, 0);
    chk("f1_pc", pc, 8'h01);
    chk("f1_req", imem_req, 1);
    // three memory wait cycles
    tick();
    chk("f1_wait2_req", imem_req, 1);
    chk("f1_wait2_addr", imem_addr, 8'h01);
    chk("f1_wait2_opcode", opcode, 8'h03);
    tick();
    chk("f1_wait3_addr", imem_addr, 8'h01);
    chk("f1_wait3_iv", instr_valid, 0);
    fetch_word(32'h05000000);
    chk("e1_iv", instr_valid, 1);
    chk("e1_opcode", opcode, 8'h05);
    tick();
    chk("f2_addr", imem_addr, 8'h02);
    // unconditional jump
    fetch_word(32'h10000040);
    jmp = 1'b1;
    tick();
    jmp = 1'b0;
    chk("jmp_addr", imem_addr, 8'h40);
    // conditional, not taken
    fetch_word(32'h11000040);
    jmp_if = 1'b1;
    cond_true = 1'b0;
    tick();
    chk("jmpif_nt_addr", imem_addr, 8'h41);
    // conditional, taken
    fetch_word(32'h12000040);
    cond_true = 1'b1;
    tick();
    jmp_if = 1'b0;
    cond_true = 1'b0;
    chk("jmpif_t_addr", imem_addr, 8'h40);
    // wrap from 8'hFF
    fetch_word(32'h130000FF);
    jmp = 1'b1;
    tick();
    jmp = 1'b0;
    chk("to_ff_addr", imem_addr, 8'hFF);
    fetch_word(32'h14000000);
    tick();
    chk("wrap_addr", imem_addr, 8'h00);
    chk("wrap_req", imem_req, 1);
    // halt beats a simultaneous jmp
    fetch_word(32'hFF000077);
    halt = 1'b1;
    jmp = 1'b1;
    tick();
    halt = 1'b0;
    jmp = 1'b0;
    chk("halt_halted", halted, 1);
    chk("halt_pc", pc, 8'h00);
    chk("halt_req", imem_req, 0);
    chk("halt_iv", instr_valid, 0);
    for (int i = 0; i < 4; i++) begin
      run = i[0];
      imem_valid = ~i[0];
      imem_rdata = 32'hAB000001;
      tick();
    end
    run = 1'b0;
    imem_valid = 1'b0;
    chk("halt_hold_halted", halted, 1);
    chk("halt_hold_pc", pc, 8'h00);
    chk("halt_hold_req", imem_req, 0);
    chk("halt_hold_opcode", opcode, 8'hFF);
    chk("halt_hold_operand", operand, 24'h000077);
    // asynchronous reset out of HALTED
    #2 rst = 1'b1;
    #1;
    chk("arst_halted", halted, 0);
    chk("arst_pc", pc, 0);
    chk("arst_opcode", opcode, 0);
    tick();
    rst = 1'b0;
    // reset mid-FETCH, then a late valid
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("mid_req_pre", imem_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_req_drop", imem_req, 0);
    rst = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = 32'hAA0000AA;
    tick();
    imem_valid = 1'b0;
    chk("late_valid_req", imem_req, 0);
    chk("late_valid_iv", instr_valid, 0);
    chk("late_valid_opcode", opcode, 0);
    tick();
    chk("late_valid_iv2", instr_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
